// File: rtl/pool_pair_feeder.sv
// pool_pair_feeder
// Upstream stage of the max-pool PE. Buffers one even row of a row-major
// plane and, on the following odd row, presents vertically aligned pixel
// pairs (x1_ = buffered even pixel, x2_ = current odd pixel) with a pulse.
// Build option: define POOL_ODD_PAD_EN to replicate-pad an odd trailing row
// (x1_ = x2_ = buffered pixel); otherwise that row is stored and dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; row_len/row_num latched on start
// EVEN_ROW | accepting an even row into line_buf
// ODD_ROW  | accepting an odd row, emitting pairs 1 cycle after handshake
// PAD_ROW  | (POOL_ODD_PAD_EN) replaying the odd trailing row as pairs
// FINISH   | one cycle to flush the last pulse, then done for one cycle

`ifndef MAC_PE_DATA_WIDTH
`define MAC_PE_DATA_WIDTH 8
`endif

module pool_pair_feeder #(
    parameter int DATA_WIDTH  = `MAC_PE_DATA_WIDTH,
    parameter int MAX_ROW_LEN = 256,
    parameter int COL_WIDTH   = 9,
    parameter int ROW_WIDTH   = 9
) (
    input  logic                  DSP_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [COL_WIDTH-1:0]  row_len,
    input  logic [ROW_WIDTH-1:0]  row_num,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  pulse,
    output logic [DATA_WIDTH-1:0] x1_,
    output logic [DATA_WIDTH-1:0] x2_,
    output logic                  busy,
    output logic                  done
);

    localparam int ADDR_WIDTH = (MAX_ROW_LEN > 1) ? $clog2(MAX_ROW_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        FINISH
`ifdef POOL_ODD_PAD_EN
        , PAD_ROW
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [COL_WIDTH-1:0]  col_q, col_d;
    logic [ROW_WIDTH-1:0]  row_q, row_d;
    logic [COL_WIDTH-1:0]  len_q, len_d;
    logic [ROW_WIDTH-1:0]  num_q, num_d;
    logic                  fin_q, fin_d;

    logic                  wr_en;
    logic                  rd_en;
    logic                  pad_sel;
    logic                  hs;
    logic                  last_col;
    logic                  last_row;
    logic [ADDR_WIDTH-1:0] addr;

    logic [DATA_WIDTH-1:0] line_buf [MAX_ROW_LEN];

    logic                  pulse_q;
    logic [DATA_WIDTH-1:0] x1_q;
    logic [DATA_WIDTH-1:0] x2_q;

    assign in_ready = (state_q == EVEN_ROW) || (state_q == ODD_ROW);
    assign hs       = in_valid & in_ready;
    assign last_col = (col_q == len_q - COL_WIDTH'(1));
    assign last_row = (row_q + ROW_WIDTH'(1) == num_q);
    assign addr     = col_q[ADDR_WIDTH-1:0];

    // done is raised on the second FINISH cycle, after the last pulse is out
    assign done     = (state_q == FINISH) && fin_q;
    assign busy     = (state_q != IDLE) && !done;

    assign pulse    = pulse_q;
    assign x1_      = x1_q;
    assign x2_      = x2_q;

    // State, counters and latched plane geometry
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            len_q   <= '0;
            num_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            len_q   <= len_d;
            num_q   <= num_d;
            fin_q   <= fin_d;
        end
    end

    // Next-state logic and line-buffer read/write strobes
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        len_d   = len_q;
        num_d   = num_q;
        fin_d   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        pad_sel = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = row_len;
                    num_d = row_num;
                    col_d = '0;
                    row_d = '0;
                    if (row_len == '0 || row_num == '0) state_d = FINISH;
                    else                                state_d = EVEN_ROW;
                end
            end
            EVEN_ROW: begin
                if (hs) begin
                    wr_en = 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + ROW_WIDTH'(1);
`ifdef POOL_ODD_PAD_EN
                        state_d = last_row ? PAD_ROW : ODD_ROW;
`else
                        state_d = last_row ? FINISH : ODD_ROW;
`endif
                    end else begin
                        col_d = col_q + COL_WIDTH'(1);
                    end
                end
            end
            ODD_ROW: begin
                if (hs) begin
                    rd_en = 1'b1;
                    if (last_col) begin
                        col_d   = '0;
                        row_d   = row_q + ROW_WIDTH'(1);
                        state_d = last_row ? FINISH : EVEN_ROW;
                    end else begin
                        col_d = col_q + COL_WIDTH'(1);
                    end
                end
            end
`ifdef POOL_ODD_PAD_EN
            PAD_ROW: begin
                rd_en   = 1'b1;
                pad_sel = 1'b1;
                if (last_col) begin
                    col_d   = '0;
                    state_d = FINISH;
                end else begin
                    col_d = col_q + COL_WIDTH'(1);
                end
            end
`endif
            FINISH: begin
                if (fin_q) state_d = IDLE;
                else       fin_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line buffer write port; contents need no reset
    always_ff @(posedge DSP_clk) begin
        if (wr_en) line_buf[addr] <= in_data;
    end

    // Pair output registers: one-cycle read latency, values hold between pulses
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
        end else begin
            pulse_q <= rd_en;
            if (rd_en) begin
                x1_q <= line_buf[addr];
                x2_q <= pad_sel ? line_buf[addr] : in_data;
            end
        end
    end

endmodule

// File: tb/tb_pool_pair_feeder.sv
// Self-checking bench for pool_pair_feeder: a fixed vector table for the
// 2x4 plane, a plane-level reference model for random and corner planes,
// and hand-written sequences for reset and start-on-done behaviour.

module tb_pool_pair_feeder;

    localparam int DW = 8;

    logic          DSP_clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [8:0]    row_len;
    logic [8:0]    row_num;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          pulse;
    logic [DW-1:0] x1_;
    logic [DW-1:0] x2_;
    logic          busy;
    logic          done;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [DW-1:0] ex1;
    logic [DW-1:0] ex2;
    logic [DW-1:0] pix [$];

    typedef struct {
        logic          start;
        logic          vld;
        logic [DW-1:0] d;
        logic          e_rdy;
        logic          e_pulse;
        logic [DW-1:0] e_x1;
        logic [DW-1:0] e_x2;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t tbl [11];

    always #5 DSP_clk = ~DSP_clk;

    pool_pair_feeder #(.DATA_WIDTH(DW)) dut (
        .DSP_clk  (DSP_clk),
        .rst_n    (rst_n),
        .start    (start),
        .row_len  (row_len),
        .row_num  (row_num),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .pulse    (pulse),
        .x1_      (x1_),
        .x2_      (x2_),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Plane-level reference: pairs are pixel[r-1][c] / pixel[r][c] for odd r,
    // each one cycle after its handshake; optional pad replays the last row.
    task automatic run_plane(input int len, input int num, input int dmode, input int vmode);
        int  total, acc, cyc, done_at, pad_len, pad_from, row, k, idle_run, budget;
        logic v, hs, e_p, exp_ready, exp_busy, exp_done;
        bit  finished;
        int  fixed8 [8] = '{1, 2, 3, 4, 8, 1, 7, 2};
        total = len * num;
        pix.delete();
        for (int i = 0; i < total; i++) begin
            case (dmode)
                1:       pix.push_back(DW'(i + 1));
                2:       pix.push_back((i < len) ? DW'(i) : DW'(2 * len - 1 - i));
                3:       pix.push_back(DW'(i + 5));
                4:       pix.push_back(DW'(fixed8[i % 8]));
                default: pix.push_back(DW'($urandom));
            endcase
        end
`ifdef POOL_ODD_PAD_EN
        pad_len = (num % 2 == 1) ? len : 0;
`else
        pad_len = 0;
`endif
        start    = 1'b1;
        row_len  = 9'(len);
        row_num  = 9'(num);
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge DSP_clk); #1;
        start    = 1'b0;
        cyc      = 0;
        acc      = 0;
        pad_from = 0;
        idle_run = 0;
        finished = 0;
        done_at  = (total == 0) ? 1 : -1;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        budget = 4 * total + len + 16;
        for (int i = 0; i < budget && !finished; i++) begin
            exp_ready = (acc < total);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0) || (idle_run >= 2);
            endcase
            idle_run = v ? 0 : idle_run + 1;
            in_valid = v;
            in_data  = (v && exp_ready) ? pix[acc] : DW'($urandom);
            chk("in_ready", in_ready, exp_ready);
            hs = v && exp_ready;
            @(posedge DSP_clk); #1;
            cyc++;
            e_p = 1'b0;
            if (hs) begin
                row = acc / len;
                if (row % 2 == 1) begin
                    e_p = 1'b1;
                    ex1 = pix[acc - len];
                    ex2 = pix[acc];
                end
                acc++;
                if (acc == total) begin
                    pad_from = cyc;
                    done_at  = cyc + 1 + pad_len;
                end
            end else if (pad_len > 0 && total > 0 && acc == total &&
                         cyc > pad_from && cyc <= pad_from + pad_len) begin
                k   = cyc - pad_from - 1;
                e_p = 1'b1;
                ex1 = pix[(num - 1) * len + k];
                ex2 = ex1;
            end
            exp_done = (done_at >= 0) && (cyc == done_at);
            exp_busy = (done_at < 0) || (cyc < done_at);
            chk("pulse", pulse, e_p);
            chk("x1", x1_, ex1);
            chk("x2", x2_, ex2);
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            if (exp_done) finished = 1;
        end
        if (!finished) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL plane_timeout len=%0d num=%0d: got no done expected done", len, num);
        end
        in_valid = 1'b0;
        @(posedge DSP_clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_ready", in_ready, 0);
        chk("idle_pulse", pulse, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'd8, 1'b1, 1'b1, 8'd1, 8'd8, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 8'd2, 8'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'd7, 1'b1, 1'b1, 8'd3, 8'd7, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 8'd4, 8'd2, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 8'd2, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 8'd2, 1'b0, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        row_len  = '0;
        row_num  = '0;
        ex1      = '0;
        ex2      = '0;
        #1;
        chk("rst_pulse", pulse, 0);
        chk("rst_x1", x1_, 0);
        chk("rst_x2", x2_, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #20;
        @(negedge DSP_clk);
        rst_n = 1'b1;
        @(posedge DSP_clk); #1;

        // 2x4 plane, in_valid held high, checked cycle by cycle
        row_len = 9'd4;
        row_num = 9'd2;
        for (int i = 0; i < 11; i++) begin
            start    = tbl[i].start;
            in_valid = tbl[i].vld;
            in_data  = tbl[i].d;
            @(posedge DSP_clk); #1;
            chk("tbl_ready", in_ready, tbl[i].e_rdy);
            chk("tbl_pulse", pulse, tbl[i].e_pulse);
            chk("tbl_x1", x1_, tbl[i].e_x1);
            chk("tbl_x2", x2_, tbl[i].e_x2);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_done", done, tbl[i].e_done);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        ex1      = 8'd4;
        ex2      = 8'd2;

        // Directed planes from the corner cases
        run_plane(4, 2, 4, 1);
        run_plane(3, 3, 1, 0);
        run_plane(0, 5, 0, 0);
        run_plane(4, 0, 0, 2);
        run_plane(1, 1, 0, 0);
        run_plane(1, 4, 0, 2);
        run_plane(256, 2, 2, 0);

        // Randomized planes
        for (int t = 0; t < 8; t++)
            run_plane(int'($urandom_range(1, 8)), int'($urandom_range(1, 5)), 0, 2);

        // start during the done cycle is ignored
        start   = 1'b1;
        row_len = 9'd0;
        row_num = 9'd1;
        @(posedge DSP_clk); #1;
        start = 1'b0;
        @(posedge DSP_clk); #1;
        chk("sod_done", done, 1);
        start   = 1'b1;
        row_len = 9'd3;
        row_num = 9'd2;
        @(posedge DSP_clk); #1;
        start = 1'b0;
        chk("sod_busy", busy, 0);
        chk("sod_ready", in_ready, 0);
        @(posedge DSP_clk); #1;
        chk("sod_busy2", busy, 0);

        // Reset in the middle of the odd row of a 4x4 plane
        start   = 1'b1;
        row_len = 9'd4;
        row_num = 9'd4;
        @(posedge DSP_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            @(posedge DSP_clk); #1;
        end
        chk("pre_rst_pulse", pulse, 1);
        chk("pre_rst_x1", x1_, 2);
        chk("pre_rst_x2", x2_, 6);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pulse", pulse, 0);
        chk("mid_rst_x1", x1_, 0);
        chk("mid_rst_x2", x2_, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        #10;
        rst_n = 1'b1;
        ex1   = '0;
        ex2   = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(posedge DSP_clk); #1;
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        run_plane(2, 2, 3, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
